dut_response_checker: RTL

- Sequential consumer sitting at the output end of the combinational `dut` in the simulation-equivalence flow.
- Accepts a stream of DUT result vectors over a valid/ready handshake and compares each against a golden (expected) vector under a per-bit compare mask.
- Counts mismatches, records the first failing vector, and folds every accepted result into a MISR signature, so original and optimized netlists are checked both per vector and by signature.

---
 rtl/dut_response_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/dut_response_checker.sv
// Output-side checker for the equivalence flow: compares DUT results to golden vectors
// under a per-bit mask, counts failures, keeps the first failure and folds results into a MISR.
module dut_response_checker #(
    parameter int               WIDTH = 80,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = {{(WIDTH-4){1'b0}}, 4'h9},
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [WIDTH-1:0] res_data,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [WIDTH-1:0] exp_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_fail_index,
    output logic [WIDTH-1:0] first_fail_diff,
    output logic [WIDTH-1:0] signature,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] idx;
    logic             xfer;
    logic [WIDTH-1:0] diff;
    logic             fail;
    logic [CNT_W-1:0] mc_next;
    logic [WIDTH-1:0] sig_next;
    logic             last;

    // Handshake: a vector (res_data/exp_data/exp_mask) transfers on a rising edge where
    // res_valid && res_ready; res_ready is a pure decode of the registered state.
    assign res_ready = (state == S_RUN);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_comb begin
        xfer     = (state == S_RUN) && res_valid;
        diff     = (res_data ^ exp_data) & exp_mask;
        fail     = |diff;
        mc_next  = (fail && (mismatch_count != CNT_MAX)) ? mismatch_count + CNT_ONE : mismatch_count;
        sig_next = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? POLY : {WIDTH{1'b0}}) ^ res_data;
        last     = (idx == num_lat - CNT_ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            num_lat          <= '0;
            idx              <= '0;
            mismatch_count   <= '0;
            first_fail_index <= '0;
            first_fail_diff  <= '0;
            signature        <= SEED;
            pass             <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_lat          <= num_vectors;
                        idx              <= '0;
                        mismatch_count   <= '0;
                        first_fail_index <= '0;
                        first_fail_diff  <= '0;
                        signature        <= SEED;
                        if (num_vectors == '0) begin
                            state <= S_DONE;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            pass  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        mismatch_count <= mc_next;
                        // Counter never wraps back to zero, so zero means no failure yet this run.
                        if (fail && (mismatch_count == '0)) begin
                            first_fail_index <= idx;
                            first_fail_diff  <= diff;
                        end
                        signature <= sig_next;
                        idx       <= idx + CNT_ONE;
                        if (last) begin
                            state <= S_DONE;
                            pass  <= (mc_next == '0);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
